test_seq_sched: RTL and testbench

TEST_SEQ_SCHED -- requirements
Module: test_seq_sched

---
 rtl/test_seq_sched.sv | 115 +++++++++++
 tb/tb_test_seq_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_seq_sched.sv
// Sequential test scheduler: walks NUM_TESTS method slots in order, raises
// one request at a time, waits for busy to drop (after a grace period) or
// for a per-test timeout, and collects per-slot pass/timeout results.
module test_seq_sched #(
  parameter int NUM_TESTS = 4,
  parameter int GRACE     = 5,
  parameter int TIMEOUT   = 100000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_TESTS-1:0]         enable_mask,
  output logic [NUM_TESTS-1:0]         test_req,
  input  logic [NUM_TESTS-1:0]         test_busy,
  input  logic [NUM_TESTS-1:0]         test_return,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_TESTS-1:0]         pass_mask,
  output logic [NUM_TESTS-1:0]         timeout_mask,
  output logic                         all_pass,
  output logic [$clog2(NUM_TESTS)-1:0] cur_index
);

  localparam int          IW      = $clog2(NUM_TESTS);
  localparam logic [31:0] TMO     = 32'(TIMEOUT);
  localparam logic [31:0] GRC     = 32'(GRACE);
  localparam logic [IW-1:0] LAST  = IW'(NUM_TESTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [31:0]          cnt, cnt_nxt;
  logic [NUM_TESTS-1:0] en_lat;
  logic                 accept, sel_en, sel_busy, sel_ret;
  logic                 complete, expire, last_slot, req_phase;

  // Decode of the current slot and the WAIT exit conditions. cnt_nxt is the
  // number of cycles since the request rose, counting the current cycle, so
  // an idle method finishes with the request high for exactly GRACE+1 cycles.
  always_comb begin
    cnt_nxt   = (cnt >= TMO) ? TMO : cnt + 32'd1;
    sel_en    = en_lat[cur_index];
    sel_busy  = test_busy[cur_index];
    sel_ret   = test_return[cur_index];
    last_slot = (cur_index == LAST);
    accept    = ((state == S_IDLE) || (state == S_DONE)) && start;
    complete  = (state == S_WAIT) && (cnt_nxt >= GRC) && !sel_busy;
    // completion takes priority over a coincident timeout
    expire    = (state == S_WAIT) && !complete && (cnt_nxt >= TMO);
    req_phase = (state == S_ISSUE) || (state == S_WAIT);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SCAN;
      S_SCAN:  state_nxt = sel_en ? S_ISSUE : S_NEXT;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (complete || expire) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_slot ? S_DONE : S_SCAN;
      S_DONE:  if (accept) state_nxt = S_SCAN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Run context: latched enables, slot pointer and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_lat    <= '0;
      cur_index <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        en_lat    <= enable_mask;
        cur_index <= '0;
      end
      if (state == S_ISSUE) cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt_nxt;
      if ((state == S_NEXT) && !last_slot) cur_index <= cur_index + 1'b1;
    end
  end

  // Result masks: cleared on an accepted start, one bit written per slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_mask    <= '0;
      timeout_mask <= '0;
    end else if (accept) begin
      pass_mask    <= '0;
      timeout_mask <= '0;
    end else begin
      if (complete) pass_mask[cur_index]    <= sel_ret;
      if (expire)   timeout_mask[cur_index] <= 1'b1;
    end
  end

  // Request outputs decode straight from state so reset drops them at once
  for (genvar i = 0; i < NUM_TESTS; i++) begin : g_req
    assign test_req[i] = req_phase && (cur_index == IW'(i));
  end

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign all_pass = done && (pass_mask == en_lat);

endmodule

// File: tb/tb_test_seq_sched.sv
// Randomized bench for test_seq_sched with a timeline reference model.
module tb_test_seq_sched;

  localparam int NT = 4;
  localparam int GR = 5;
  localparam int TO = 50;

  logic          clk = 0;
  logic          rst;
  logic          start;
  logic [NT-1:0] enable_mask;
  logic [NT-1:0] test_req, test_busy, test_return;
  logic          busy, done, all_pass;
  logic [NT-1:0] pass_mask, timeout_mask;
  logic [1:0]    cur_index;

  test_seq_sched #(.NUM_TESTS(NT), .GRACE(GR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst), .start(start), .enable_mask(enable_mask),
    .test_req(test_req), .test_busy(test_busy), .test_return(test_return),
    .busy(busy), .done(done), .pass_mask(pass_mask),
    .timeout_mask(timeout_mask), .all_pass(all_pass), .cur_index(cur_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Method responders: slot i goes busy d_cfg[i] cycles after its request
  // rises and stays busy b_cfg[i] cycles (b_cfg < 0: stuck busy).
  int         d_cfg [NT];
  int         b_cfg [NT];
  logic [NT-1:0] ret_cfg;
  int         off [NT];

  always @(posedge clk)
    for (int i = 0; i < NT; i++) off[i] <= test_req[i] ? off[i] + 1 : 0;

  always_comb begin
    test_busy = '0;
    for (int i = 0; i < NT; i++)
      test_busy[i] = test_req[i] && off[i] >= d_cfg[i] &&
                     (b_cfg[i] < 0 || off[i] < d_cfg[i] + b_cfg[i]);
  end
  assign test_return = ret_cfg;

  // Reference model: at each accepted start, lay out the whole run as a list
  // of per-cycle expected outputs (slot index, request, masks so far).
  typedef struct packed {
    logic [1:0]    idx;
    logic [NT-1:0] req;
    logic [NT-1:0] pass;
    logic [NT-1:0] to;
  } step_t;

  step_t       trace[$];
  int          pos;
  bit          running;
  logic [16:0] hold;   // {busy, done, all_pass, idx, req, pass, to} outside a run

  // cycle offset (request rise = 0) at which slot i finishes
  function automatic int slot_finish(input int i, output bit timed);
    for (int k = 1; k <= TO; k++) begin
      bit b;
      b = (k >= d_cfg[i]) && (b_cfg[i] < 0 || k < d_cfg[i] + b_cfg[i]);
      if (k >= GR && !b) begin
        timed = 0;
        return k;
      end
    end
    timed = 1;
    return TO;
  endfunction

  function automatic void build_run(input logic [NT-1:0] en);
    logic [NT-1:0] p, t;
    int            k;
    bit            timed;
    p = '0; t = '0;
    trace.delete();
    for (int i = 0; i < NT; i++) begin
      trace.push_back('{2'(i), '0, p, t});                    // scan
      if (en[i]) begin
        k = slot_finish(i, timed);
        for (int o = 0; o <= k; o++)
          trace.push_back('{2'(i), NT'(1 << i), p, t});       // issue + wait
        if (timed) t[i] = 1'b1;
        else       p[i] = ret_cfg[i];
      end
      trace.push_back('{2'(i), '0, p, t});                    // next
    end
    hold = {1'b0, 1'b1, (p == en), 2'(NT - 1), NT'(0), p, t};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      running = 0;
      pos     = 0;
      hold    = '0;
    end else if (running) begin
      pos++;
      if (pos >= trace.size()) running = 0;
    end else if (start) begin
      build_run(enable_mask);
      running = 1;
      pos     = 0;
    end
  end

  // Cycle compare of every output against the model
  always @(negedge clk) begin
    logic [16:0] exp, act;
    exp = running ? {1'b1, 1'b0, 1'b0, trace[pos]} : hold;
    act = {busy, done, all_pass, cur_index, test_req, pass_mask, timeout_mask};
    chk("cycle_outputs", 32'(act), 32'(exp));
  end

  // Request-length monitor
  int        cur_len [NT];
  int        last_len [NT];
  logic [NT-1:0] seen;

  always @(negedge clk)
    for (int i = 0; i < NT; i++) begin
      if (test_req[i]) begin
        cur_len[i]++;
        seen[i] = 1'b1;
      end else if (cur_len[i] > 0) begin
        last_len[i] = cur_len[i];
        cur_len[i]  = 0;
      end
    end

  int run_cycles;

  task automatic cfg_all(input int d, input int b, input logic [NT-1:0] r);
    for (int i = 0; i < NT; i++) begin
      d_cfg[i] = d;
      b_cfg[i] = b;
    end
    ret_cfg = r;
  endtask

  // Start a run and wait for done; noise pulses start and scrambles the
  // enable input while the run is in progress.
  task automatic run(input logic [NT-1:0] en, input bit noise);
    bit ok;
    enable_mask = en;
    seen        = '0;
    start       = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    run_cycles = 0;
    ok         = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      run_cycles++;
      if (done) begin
        ok = 1;
        break;
      end
      if (noise) begin
        start       = 1'($urandom_range(0, 1));
        enable_mask = NT'($urandom);
      end
    end
    start = 1'b0;
    if (!ok) chk("run_done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    enable_mask = '0;
    seen        = '0;
    for (int i = 0; i < NT; i++) begin
      cur_len[i]  = 0;
      last_len[i] = 0;
    end
    cfg_all(0, 0, '1);
    repeat (3) @(negedge clk);
    chk("reset_req",  32'(test_req), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_masks", 32'({pass_mask, timeout_mask}), 32'd0);
    chk("reset_allpass_idx", 32'({all_pass, cur_index}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // all slots busy 20 cycles, all pass
    cfg_all(1, 20, 4'b1111);
    run(4'b1111, 0);
    chk("r35_pass", 32'(pass_mask), 32'hf);
    chk("r35_allpass", 32'(all_pass), 32'd1);
    chk("r35_seen", 32'(seen), 32'hf);
    chk("r35_len0", 32'(last_len[0]), 32'd22);

    // sparse enable, slot 2 fails
    cfg_all(2, 3, 4'b1011);
    run(4'b0101, 0);
    chk("r36_pass", 32'(pass_mask), 32'h1);
    chk("r36_allpass", 32'(all_pass), 32'd0);
    chk("r36_seen", 32'(seen), 32'h5);

    // slot 1 stuck busy -> timeout, later slots still run
    cfg_all(0, 0, 4'b1111);
    b_cfg[1] = -1;
    run(4'b1111, 0);
    chk("r37_timeout", 32'(timeout_mask), 32'h2);
    chk("r37_pass", 32'(pass_mask), 32'hd);
    chk("r37_len1", 32'(last_len[1]), 32'd51);
    chk("r37_seen", 32'(seen), 32'hf);

    // busy never rises: request high GRACE+1 cycles
    cfg_all(0, 0, 4'b1111);
    run(4'b0001, 0);
    chk("r38_len0", 32'(last_len[0]), 32'd6);
    chk("r38_pass_allpass", 32'({all_pass, pass_mask}), 32'h11);

    // empty enable: NUM_TESTS scan/next pairs then done
    run(4'b0000, 0);
    chk("r30_cycles", 32'(run_cycles), 32'd8);
    chk("r30_allpass", 32'(all_pass), 32'd1);

    // reset 10 cycles into slot 2 wait
    b_cfg[2] = -1;
    enable_mask = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && !test_req[2]; c++) @(negedge clk);
    chk("r39_req2_rose", 32'(test_req[2]), 32'd1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("r39_async_req", 32'(test_req), 32'd0);
    chk("r39_async_status", 32'({busy, done, all_pass, cur_index}), 32'd0);
    chk("r39_async_masks", 32'({pass_mask, timeout_mask}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("r39_stays_idle", 32'({busy, done}), 32'd0);
    b_cfg[2] = 0;
    run(4'b1111, 0);
    chk("r39_rerun_pass", 32'(pass_mask), 32'hf);
    chk("r39_rerun_seen", 32'(seen), 32'hf);

    // start noise during a run, restart from done clears masks
    b_cfg[3] = -1;
    run(4'b1000, 1);
    chk("r40_timeout", 32'(timeout_mask), 32'h8);
    b_cfg[3] = 0;
    run(4'b0000, 1);
    chk("r40_cleared", 32'({timeout_mask, pass_mask}), 32'd0);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NT; i++) begin
        d_cfg[i] = $urandom_range(0, 6);
        b_cfg[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
      end
      ret_cfg = NT'($urandom);
      run(NT'($urandom), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
